// File: rtl/write_queue.sv
// Wide-to-narrow serializer for the kernel output path: each IN_WIDTH word
// leaves as IN_WIDTH/OUT_WIDTH OUT_WIDTH beats, least-significant slice first.
module write_queue #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  input  logic                 ap_start
);

  localparam int MAX = IN_WIDTH / OUT_WIDTH;
  localparam int CW  = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IN_WIDTH-1:0]  shreg_q;
  logic [OUT_WIDTH-1:0] dout_q;
  logic                 vld_out_q;
  logic                 ap_start_q;

  logic start_pulse;
  logic last_beat;
  logic up_xfer;
  logic dn_xfer;

  assign start_pulse = ap_start & ~ap_start_q;
  assign last_beat   = (state_q == SEND) && (cnt_q == LAST);

  // A new word is taken only when nothing is left to send after this cycle,
  // which lets the last beat and the next word's load share a clock edge.
  assign rdy_upward = ~start_pulse & ((state_q == IDLE) | (last_beat & rdy_downward));
  assign up_xfer    = vld_in & rdy_upward;
  assign dn_xfer    = vld_out_q & rdy_downward & ~start_pulse;

  assign dout    = dout_q;
  assign vld_out = vld_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ap_start_q <= 1'b0;
    end else begin
      ap_start_q <= ap_start;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      vld_out_q <= 1'b0;
    end else if (start_pulse) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      vld_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (up_xfer) begin
            shreg_q   <= din >> OUT_WIDTH;
            dout_q    <= din[OUT_WIDTH-1:0];
            vld_out_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (dn_xfer) begin
            if (!last_beat) begin
              dout_q  <= shreg_q[OUT_WIDTH-1:0];
              shreg_q <= shreg_q >> OUT_WIDTH;
              cnt_q   <= cnt_q + 1'b1;
            end else if (up_xfer) begin
              shreg_q   <= din >> OUT_WIDTH;
              dout_q    <= din[OUT_WIDTH-1:0];
              vld_out_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= SEND;
            end else begin
              vld_out_q <= 1'b0;
              dout_q    <= '0;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/write_queue.md
Name: write_queue

Overview:
- Width down-converter (serializer) on the kernel output path. It is the transmit-side counterpart of the narrow-to-wide read packer.
- Accepts one IN_WIDTH word per valid/ready handshake from the upstream kernel.
- Emits it as MAX = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH beats toward the narrow stream, least-significant slice first.
- A rising edge on ap_start soft-clears all state so each kernel invocation starts clean.

Parameters:
- IN_WIDTH, 64, wide input word width.
- OUT_WIDTH, 32, narrow output beat width.
- MAX (localparam), IN_WIDTH/OUT_WIDTH, beats per word. IN_WIDTH must be an integer multiple of OUT_WIDTH, and MAX >= 2.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  IN_WIDTH  wide word from upstream.
- vld_in  input  1  din valid.
- rdy_upward  output  1  block can accept din this cycle.
- dout  output  OUT_WIDTH  narrow beat, registered.
- vld_out  output  1  dout valid, registered.
- rdy_downward  input  1  downstream accepts dout this cycle.
- ap_start  input  1  kernel start level; its rising edge is the soft reset.

Behaviour:
- Async reset (reset=1, immediate, no clock needed):
  - state=IDLE, cnt=0, shreg=0.
  - dout=0, vld_out=0, ap_start_q=0.
- Edge detect:
  - ap_start_q <= ap_start every cycle.
  - start_pulse = ap_start & ~ap_start_q (combinational).
- Soft reset (start_pulse=1):
  - At that clock edge: state=IDLE, cnt=0, shreg=0, dout=0, vld_out=0.
  - During the start_pulse cycle, rdy_upward is forced 0 and any downstream handshake is ignored. No word is accepted or lost in that cycle.
  - A soft reset mid-word discards the remaining beats.
- Handshakes:
  - Upstream transfer: vld_in & rdy_upward.
  - Downstream transfer: vld_out & rdy_downward.
  - vld_out/dout hold stable until a downstream transfer completes. Never deassert vld_out or change dout while vld_out=1 and rdy_downward=0.
- State IDLE:
  - rdy_upward=1 (unless start_pulse); vld_out=0.
  - On an upstream transfer: shreg <= din >> OUT_WIDTH, dout <= din[OUT_WIDTH-1:0], vld_out <= 1, cnt <= 0, go to SEND.
  - Latency: first beat is valid the cycle after acceptance.
- State SEND:
  - cnt is the index of the beat currently on dout (0..MAX-1).
  - Downstream transfer with cnt < MAX-1: dout <= shreg[OUT_WIDTH-1:0], shreg <= shreg >> OUT_WIDTH, cnt <= cnt+1.
  - rdy_upward = (cnt == MAX-1) & rdy_downward. This is combinational and allows a zero-bubble refill.
  - Last-beat transfer with an upstream transfer in the same cycle: load the new word exactly as in IDLE and stay in SEND with cnt=0.
  - Last-beat transfer without an upstream transfer: vld_out <= 0, dout <= 0, go to IDLE.
  - No downstream transfer: hold all state.
- Throughput: back-to-back words give 100% output beat utilisation, MAX output beats per input word.
- Ordering: beat k = din[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH]. This is the exact inverse of the read packer, so a loopback through the read packer reproduces the original words.
- cnt width: $clog2(MAX), minimum 1 bit. It never exceeds MAX-1.
- rdy_upward is combinational from state, cnt and rdy_downward. It never depends on vld_in.

Test Plan:
- Reset, then din=64'hAAAA_BBBB_CCCC_DDDD with vld_in pulsed 1 cycle and rdy_downward=1 -> dout=32'hCCCC_DDDD, then 32'hAAAA_BBBB on consecutive cycles. vld_out is high exactly 2 cycles, starting 1 cycle after acceptance.
- Three words (0x1..0x2, 0x3..0x4, 0x5..0x6) streamed with vld_in=1 and rdy_downward=1 -> 6 beats with no vld_out gap; rdy_upward=1 only on last-beat cycles.
- Same word with rdy_downward toggled 1,0,0,1 -> dout and vld_out hold through the stall cycles, and rdy_upward=0 until the last beat is accepted.
- ap_start rising edge after beat 0 of 0xDEAD_BEEF_0123_4567 -> next cycle vld_out=0, dout=0, state IDLE; beat 0xDEAD_BEEF is never emitted, and rdy_upward=0 during the pulse cycle.
- Async reset asserted mid-SEND between clock edges -> vld_out=0 and dout=0 immediately. After release, a new word serializes correctly from beat 0.
- IN_WIDTH=128, OUT_WIDTH=32: din=128'h4444..._3333..._2222..._1111... -> beats 0x1111..., 0x2222..., 0x3333..., 0x4444... in that order. cnt wraps 3->0 on a back-to-back reload.
